// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, function
// codes, ALU controls, state and instruction-class encodings.
package multicycle_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function field
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b1010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_J   = 3'd1,
    CLS_ORI = 3'd2,
    CLS_LW  = 3'd3,
    CLS_SW  = 3'd4
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [2:0] alu_func;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: purely combinational op/func classifier feeding the
// DECODE-stage latches of multicycle_ctrl.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [3:0] func_i,
  output dec_t       dec_o
);

  // Map opcode/function to instruction class, ALU op and legality
  always_comb begin
    dec_o.cls      = CLS_R;
    dec_o.alu_func = ALU_ADD;
    dec_o.illegal  = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        dec_o.cls = CLS_R;
        case (func_i)
          FN_ADD:  dec_o.alu_func = ALU_ADD;
          FN_SUB:  dec_o.alu_func = ALU_SUB;
          FN_AND:  dec_o.alu_func = ALU_AND;
          FN_OR:   dec_o.alu_func = ALU_OR;
          FN_SLT:  dec_o.alu_func = ALU_SLT;
          default: dec_o.illegal  = 1'b1;
        endcase
      end
      OP_J: begin
        dec_o.cls = CLS_J;
      end
      OP_ORI: begin
        dec_o.cls      = CLS_ORI;
        dec_o.alu_func = ALU_OR;
      end
      OP_LW: begin
        dec_o.cls = CLS_LW;
      end
      OP_SW: begin
        dec_o.cls = CLS_SW;
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state control FSM sequencing a shared datapath
// through fetch, decode, execute, memory and write-back over a single
// ready-handshaked memory port. Also counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [3:0]  func,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_func,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        wb_sel,
  output logic        illegal_instr,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  class_e      cls_q, cls_d;
  logic [2:0]  alu_func_q, alu_func_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        retire_s;
  dec_t        dec_s;

  mc_decode u_decode (
    .op_i   (op),
    .func_i (func),
    .dec_o  (dec_s)
  );

  // State register, decode latches and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      cls_q         <= CLS_R;
      alu_func_q    <= ALU_ADD;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      alu_func_q    <= alu_func_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next state, DECODE-stage latch loading and retire detection
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_func_d = alu_func_q;
    retire_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        cls_d      = dec_s.cls;
        alu_func_d = dec_s.alu_func;
        if (dec_s.illegal) begin
          state_d = ST_FETCH;
        end else if (dec_s.cls == CLS_J) begin
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_ORI: state_d = ST_WB;
          CLS_LW, CLS_SW: state_d = ST_MEM;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready) begin
          state_d = ST_MEM;
        end else if (cls_q == CLS_SW) begin
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end else if (cls_q == CLS_LW) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (retire_s) instr_count_d = instr_count_q + 16'd1;
    else          instr_count_d = instr_count_q;
  end

  // Datapath controls per state; FETCH completion strobes follow mem_ready
  // in the same cycle, and everything is held low while reset is asserted
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_func      = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    wb_sel        = 1'b0;
    illegal_instr = 1'b0;
    state         = state_q;
    instr_count   = instr_count_q;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        if (dec_s.illegal) begin
          illegal_instr = 1'b1;
        end else if (dec_s.cls == CLS_J) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else begin
          pc_write = 1'b0;
        end
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        case (cls_q)
          CLS_R: begin
            alu_src_b = SRCB_REG;
            alu_func  = alu_func_q;
          end
          CLS_ORI: begin
            alu_src_b = SRCB_IMM;
            alu_func  = ALU_OR;
          end
          CLS_LW, CLS_SW: begin
            alu_src_b = SRCB_IMM;
            alu_func  = ALU_ADD;
          end
          default: begin
            alu_src_b = SRCB_REG;
          end
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CLS_SW);
      end
      ST_WB: begin
        reg_write = 1'b1;
        reg_dst   = (cls_q == CLS_R);
        wb_sel    = (cls_q == CLS_LW);
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
    if (rst) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_func      = 3'b000;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      wb_sel        = 1'b0;
      illegal_instr = 1'b0;
      state         = 3'd0;
      instr_count   = 16'd0;
    end else begin
      state = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Each step drives the
// inputs, pushes the expected output vector onto a scoreboard queue, and
// the vector is popped and compared mid-cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [3:0]  func;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
  logic        alu_src_a, reg_write, reg_dst, wb_sel, illegal_instr;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_func, state;
  logic [15:0] instr_count;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_func;
    logic        reg_write;
    logic        reg_dst;
    logic        wb_sel;
    logic        illegal_instr;
    logic [2:0]  state;
    logic [15:0] instr_count;
  } exp_t;

  exp_t   exp_q[$];
  string  tag_q[$];
  int     errors = 0;
  int     checks = 0;
  logic [15:0] cnt = 16'd0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_func(alu_func),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .illegal_instr(illegal_instr), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t e_zero();
    exp_t e = '0;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy, input logic [15:0] c);
    exp_t e = '0;
    e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_func = 3'b000;
    e.ir_write = rdy; e.pc_write = rdy; e.state = 3'd0; e.instr_count = c;
    return e;
  endfunction

  // kind: 0 = goes on to EXEC, 1 = jump, 2 = illegal
  function automatic exp_t e_dec(input int kind, input logic [15:0] c);
    exp_t e = '0;
    e.state = 3'd1; e.instr_count = c;
    if (kind == 1) begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
    if (kind == 2) e.illegal_instr = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [1:0] sb, input logic [2:0] af, input logic [15:0] c);
    exp_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = sb; e.alu_func = af;
    e.state = 3'd2; e.instr_count = c;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic we, input logic [15:0] c);
    exp_t e = '0;
    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = we;
    e.state = 3'd3; e.instr_count = c;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic dst, input logic ws, input logic [15:0] c);
    exp_t e = '0;
    e.reg_write = 1'b1; e.reg_dst = dst; e.wb_sel = ws;
    e.state = 3'd4; e.instr_count = c;
    return e;
  endfunction

  // One clock cycle: drive, push expectation, compare mid-cycle
  task automatic step(input logic r, input logic [5:0] o, input logic [3:0] f,
                      input logic rdy, input exp_t e, input string tag);
    exp_t  want;
    exp_t  got;
    string t;
    rst = r; op = o; func = f; mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    got  = '{mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_func, reg_write, reg_dst, wb_sel,
             illegal_instr, state, instr_count};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fn_tab [5];
  logic [2:0] af_tab [5];

  initial begin
    fn_tab = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010};
    af_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    rst = 1'b1; op = 6'd0; func = 4'd0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset: everything low
    step(1'b1, 6'h3F, 4'hF, 1'b1, e_zero(), "reset0");
    step(1'b1, 6'h00, 4'h0, 1'b1, e_zero(), "reset1");

    // R-type group; op/func scrambled after DECODE to prove latching
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'h00, fn_tab[i], 1'b1, e_fetch(1'b1, cnt), "r_fetch");
      step(1'b0, 6'h00, fn_tab[i], 1'b1, e_dec(0, cnt), "r_decode");
      step(1'b0, 6'h23, 4'hF, 1'b1, e_exec(2'b00, af_tab[i], cnt), "r_exec");
      step(1'b0, 6'h2B, 4'h3, 1'b1, e_wb(1'b1, 1'b0, cnt), "r_wb");
      cnt++;
    end

    // ori, with one fetch wait state
    step(1'b0, 6'h0D, 4'h0, 1'b0, e_fetch(1'b0, cnt), "ori_fetch_wait");
    step(1'b0, 6'h0D, 4'h0, 1'b1, e_fetch(1'b1, cnt), "ori_fetch");
    step(1'b0, 6'h0D, 4'h0, 1'b1, e_dec(0, cnt), "ori_decode");
    step(1'b0, 6'h00, 4'h2, 1'b1, e_exec(2'b10, 3'b011, cnt), "ori_exec");
    step(1'b0, 6'h00, 4'h2, 1'b1, e_wb(1'b0, 1'b0, cnt), "ori_wb");
    cnt++;

    // lw with two MEM wait states: 7 cycles total
    step(1'b0, 6'h23, 4'h0, 1'b1, e_fetch(1'b1, cnt), "lw_fetch");
    step(1'b0, 6'h23, 4'h0, 1'b1, e_dec(0, cnt), "lw_decode");
    step(1'b0, 6'h23, 4'h0, 1'b1, e_exec(2'b10, 3'b000, cnt), "lw_exec");
    step(1'b0, 6'h23, 4'h0, 1'b0, e_mem(1'b0, cnt), "lw_mem_wait1");
    step(1'b0, 6'h23, 4'h0, 1'b0, e_mem(1'b0, cnt), "lw_mem_wait2");
    step(1'b0, 6'h23, 4'h0, 1'b1, e_mem(1'b0, cnt), "lw_mem_done");
    step(1'b0, 6'h23, 4'h0, 1'b1, e_wb(1'b0, 1'b1, cnt), "lw_wb");
    cnt++;

    // sw then j
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_fetch(1'b1, cnt), "sw_fetch");
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_dec(0, cnt), "sw_decode");
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_exec(2'b10, 3'b000, cnt), "sw_exec");
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_mem(1'b1, cnt), "sw_mem");
    cnt++;
    step(1'b0, 6'h02, 4'h0, 1'b1, e_fetch(1'b1, cnt), "j_fetch");
    step(1'b0, 6'h02, 4'h0, 1'b1, e_dec(1, cnt), "j_decode");
    cnt++;

    // Illegal opcode, then illegal R-type function; count unchanged
    step(1'b0, 6'h0F, 4'h0, 1'b1, e_fetch(1'b1, cnt), "ill_op_fetch");
    step(1'b0, 6'h0F, 4'h0, 1'b1, e_dec(2, cnt), "ill_op_decode");
    step(1'b0, 6'h00, 4'hF, 1'b1, e_fetch(1'b1, cnt), "ill_fn_fetch");
    step(1'b0, 6'h00, 4'hF, 1'b1, e_dec(2, cnt), "ill_fn_decode");
    step(1'b0, 6'h00, 4'hF, 1'b0, e_fetch(1'b0, cnt), "ill_back_fetch");

    // Reset during MEM of a stalled sw
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_fetch(1'b1, cnt), "rst_sw_fetch");
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_dec(0, cnt), "rst_sw_decode");
    step(1'b0, 6'h2B, 4'h0, 1'b1, e_exec(2'b10, 3'b000, cnt), "rst_sw_exec");
    step(1'b0, 6'h2B, 4'h0, 1'b0, e_mem(1'b1, cnt), "rst_sw_mem");
    step(1'b1, 6'h2B, 4'h0, 1'b0, e_zero(), "rst_in_mem");
    step(1'b1, 6'h2B, 4'h0, 1'b1, e_zero(), "rst_hold");
    cnt = 16'd0;
    step(1'b0, 6'h02, 4'h0, 1'b0, e_fetch(1'b0, cnt), "rst_release_fetch");
    step(1'b0, 6'h02, 4'h0, 1'b1, e_fetch(1'b1, cnt), "post_rst_fetch");
    step(1'b0, 6'h02, 4'h0, 1'b1, e_dec(1, cnt), "post_rst_j");
    cnt++;

    // Counter wrap: preload the counter near the top while idling in FETCH
    force dut.instr_count_q = 16'hFFFE;
    cnt = 16'hFFFE;
    step(1'b0, 6'h02, 4'h0, 1'b0, e_fetch(1'b0, cnt), "wrap_preload");
    release dut.instr_count_q;
    step(1'b0, 6'h02, 4'h0, 1'b0, e_fetch(1'b0, cnt), "wrap_hold");
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 6'h02, 4'h0, 1'b1, e_fetch(1'b1, cnt), "wrap_fetch");
      step(1'b0, 6'h02, 4'h0, 1'b1, e_dec(1, cnt), "wrap_j");
      cnt++;
    end
    step(1'b0, 6'h02, 4'h0, 1'b0, e_fetch(1'b0, cnt), "wrap_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
